// File: rtl/arith_multicycle_pkg.sv
// Shared types for the slice-serial arithmetic block: operation codes and FSM states.
package arith_multicycle_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_INC   = 3'd2,
    OP_DEC   = 3'd3,
    OP_PASSA = 3'd4,
    OP_NEG   = 3'd5,
    OP_SUBB  = 3'd6,
    OP_PASSB = 3'd7
  } opsel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/arith_block_multicycle_slice.sv
// Combinational SLICE-bit adder; also exposes the carry into its MSB so the
// top slice can produce the signed-overflow flag.
module arith_slice #(
  parameter int SLICE = 32
) (
  input  logic [SLICE-1:0] X,
  input  logic [SLICE-1:0] Y,
  input  logic             Ci,
  output logic [SLICE-1:0] S,
  output logic             Co,
  output logic             Cm
);

  always_comb begin
    {Co, S} = {1'b0, X} + {1'b0, Y} + {{SLICE{1'b0}}, Ci};
    // Sum bit = x ^ y ^ carry_in, so the MSB carry-in falls out of the sum.
    Cm = S[SLICE-1] ^ X[SLICE-1] ^ Y[SLICE-1];
  end

endmodule

// File: rtl/arith_block_multicycle.sv
// Slice-serial WIDTH-bit arithmetic unit: one SLICE-bit slice per clock, LSB first.
// Optional Overflow/Zero flag outputs are enabled with the ARITH_FLAGS_EN macro.
module arith_block_multicycle #(
  parameter int WIDTH = 128,
  parameter int SLICE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout
`ifdef ARITH_FLAGS_EN
  ,
  output logic             Overflow,
  output logic             Zero
`endif
);
  import arith_multicycle_pkg::*;

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("arith_block_multicycle: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_c0;
  logic [SLICE-1:0] w_xs;
  logic [SLICE-1:0] w_ys;
  logic [SLICE-1:0] w_s;
  logic             w_co;
  logic             w_cm;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // Every op reduces to X + Y + c0; operand inversion/constants are chosen here.
  always_comb begin
    w_x  = A;
    w_y  = '0;
    w_c0 = 1'b0;
    case (opsel_e'(opsel))
      OP_ADD:   begin w_y = B;          w_c0 = Cin;  end
      OP_SUB:   begin w_y = ~B;         w_c0 = 1'b1; end
      OP_INC:   begin                   w_c0 = 1'b1; end
      OP_DEC:   begin w_y = '1;                      end
      OP_PASSA: begin                                end
      OP_NEG:   begin w_x = ~A;         w_c0 = 1'b1; end
      OP_SUBB:  begin w_y = ~B;         w_c0 = Cin;  end
      OP_PASSB: begin w_x = B;                       end
      default:  begin                                end
    endcase
  end

  assign w_xs   = r_x[r_idx*SLICE +: SLICE];
  assign w_ys   = r_y[r_idx*SLICE +: SLICE];
  assign w_last = (r_idx == IW'(N - 1));

  arith_slice #(.SLICE(SLICE)) u_slice (
    .X  (w_xs),
    .Y  (w_ys),
    .Ci (r_carry),
    .S  (w_s),
    .Co (w_co),
    .Cm (w_cm)
  );

  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[r_idx*SLICE +: SLICE] = w_s;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= w_x;
            r_y     <= w_y;
            r_carry <= w_c0;
            r_idx   <= '0;
          end
        end
        S_BUSY: begin
          r_res   <= w_res_nxt;
          r_carry <= w_co;
          if (w_last) begin
            r_cout <= w_co;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result = r_res;
  assign Cout   = r_cout;

`ifdef ARITH_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  // Flags are captured with the final slice so they track Result exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == S_BUSY && w_last) begin
      r_ovf  <= w_cm ^ w_co;
      r_zero <= (w_res_nxt == '0);
    end
  end

  assign Overflow = r_ovf;
  assign Zero     = r_zero;
`else
  logic w_unused_cm;
  assign w_unused_cm = w_cm;
`endif

endmodule

// File: tb/tb_arith_block_multicycle.sv
// Directed bench for arith_block_multicycle at WIDTH=128, SLICE=32 (four slices).
module tb_arith_block_multicycle;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic [2:0]   opsel = 3'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Result;
  logic         Cout;
`ifdef ARITH_FLAGS_EN
  logic         Overflow;
  logic         Zero;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

  arith_block_multicycle #(.WIDTH(128), .SLICE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .opsel     (opsel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Cout      (Cout)
`ifdef ARITH_FLAGS_EN
    ,
    .Overflow  (Overflow),
    .Zero      (Zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rel_inrdy"}, in_ready, 1);
    chk({tag, "_rel_ovld"}, out_valid, 0);
  endtask

  // Issue one op, scramble the inputs after acceptance, and check latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [2:0] op,
                        input logic [W-1:0] exp_r, input logic exp_c, input bit rel);
    int busy = 0;
    int n = 0;
    A = a; B = b; Cin = ci; opsel = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = {$urandom, $urandom, $urandom, $urandom};
    B = {$urandom, $urandom, $urandom, $urandom};
    Cin = ~ci;
    opsel = ~op;
    while (!out_valid && n < 20) begin
      if (!in_ready) busy++;
      step();
      n++;
    end
    chk({tag, "_ovld"}, out_valid, 1);
    chk({tag, "_busy"}, W'(busy), 4);
    chk({tag, "_res"}, Result, exp_r);
    chk({tag, "_cout"}, Cout, exp_c);
    if (rel) release_out(tag);
  endtask

  initial begin
    int ovl;
    logic [W-1:0] hold_r;
    logic         hold_c;

    step(); step();
    rst = 1'b0;
    chk("rst_inrdy", in_ready, 1);
    chk("rst_ovld", out_valid, 0);
    chk("rst_res", Result, 0);
    chk("rst_cout", Cout, 0);

    run_op("add_wrap", ONES, 1, 1'b0, 3'd0, 0, 1'b1, 1);
    run_op("sub_5_7", 5, 7, 1'b0, 3'd1, ONES - 1, 1'b0, 1);
    run_op("sub_7_5", 7, 5, 1'b0, 3'd1, 2, 1'b1, 1);
    run_op("inc_x", 128'hFFFF_FFFF, 0, 1'b0, 3'd2, 128'h1_0000_0000, 1'b0, 1);
    run_op("subb_c0", 7, 5, 1'b0, 3'd6, 1, 1'b1, 1);

    // All ops with A = 2^127, B = 1, Cin = 1.
    run_op("op_add",   MSB, 1, 1'b1, 3'd0, MSB + 2, 1'b0, 1);
    run_op("op_sub",   MSB, 1, 1'b1, 3'd1, MAXP,    1'b1, 1);
    run_op("op_inc",   MSB, 1, 1'b1, 3'd2, MSB + 1, 1'b0, 1);
    run_op("op_dec",   MSB, 1, 1'b1, 3'd3, MAXP,    1'b1, 1);
    run_op("op_passa", MSB, 1, 1'b1, 3'd4, MSB,     1'b0, 1);
    run_op("op_neg",   MSB, 1, 1'b1, 3'd5, MSB,     1'b0, 1);
    run_op("op_subb",  MSB, 1, 1'b1, 3'd6, MAXP,    1'b1, 1);
    run_op("op_passb", MSB, 1, 1'b1, 3'd7, 1,       1'b0, 1);

    // Backpressure: DONE held with a competing request on the input.
    run_op("bp", 3, 4, 1'b0, 3'd0, 7, 1'b0, 0);
    hold_r = 7;
    hold_c = 1'b0;
    A = 100; B = 200; opsel = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_res", Result, hold_r);
      chk("bp_cout", Cout, hold_c);
      chk("bp_inrdy", in_ready, 0);
      chk("bp_ovld", out_valid, 1);
    end
    in_valid = 1'b0;
    release_out("bp");

    // Reset during the second BUSY cycle.
    A = ONES; B = ONES; Cin = 1'b1; opsel = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ovld", out_valid, 0);
    chk("mid_rst_res", Result, 0);
    chk("mid_rst_cout", Cout, 0);
    chk("mid_rst_inrdy", in_ready, 1);
    ovl = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) ovl++;
    end
    chk("mid_rst_stale", W'(ovl), 0);
    run_op("post_rst", 10, 20, 1'b1, 3'd0, 31, 1'b0, 1);

`ifdef ARITH_FLAGS_EN
    run_op("flg_ovf", MAXP, 1, 1'b0, 3'd0, MSB, 1'b0, 0);
    chk("flg_ovf_v", Overflow, 1);
    chk("flg_ovf_z", Zero, 0);
    release_out("flg_ovf");
    run_op("flg_zero", 128'h1234, 128'h1234, 1'b0, 3'd1, 0, 1'b1, 0);
    chk("flg_zero_z", Zero, 1);
    chk("flg_zero_v", Overflow, 0);
    release_out("flg_zero");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
